// File: rtl/data_sram_like_slave.sv
// Data-side SRAM-like responder: word-addressed memory behind an in-order
// request queue that answers each request after a fixed latency.
module data_sram_like_slave #(
    parameter int ADDR_WIDTH  = 12,
    parameter int LATENCY     = 2,
    parameter int QUEUE_DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  data_sram_req,
    input  logic                  data_sram_wr,
    input  logic [1:0]            data_sram_size,
    input  logic [3:0]            data_sram_wstrb,
    input  logic [31:0]           data_sram_addr,
    input  logic [31:0]           data_sram_wdata,
    output logic                  data_sram_addr_ok,
    output logic                  data_sram_data_ok,
    output logic [31:0]           data_sram_rdata,
    input  logic                  resp_stall
);

    localparam int PTR_W = $clog2(QUEUE_DEPTH);
    localparam logic [3:0] TIMER_INIT = 4'(LATENCY - 1);
    localparam logic [PTR_W:0] DEPTH_CNT = (PTR_W + 1)'(QUEUE_DEPTH);

    logic [31:0]           mem [2**ADDR_WIDTH];

    logic [PTR_W-1:0]      head;
    logic [PTR_W-1:0]      tail;
    logic [PTR_W:0]        count;
    logic [QUEUE_DEPTH-1:0] q_valid;
    logic [QUEUE_DEPTH-1:0] q_wr;
    logic [3:0]            q_wstrb [QUEUE_DEPTH];
    logic [ADDR_WIDTH-1:0] q_idx   [QUEUE_DEPTH];
    logic [31:0]           q_wdata [QUEUE_DEPTH];
    logic [3:0]            q_timer [QUEUE_DEPTH];

    logic                  accept;
    logic                  resp_fire;
    logic                  unused_bits;

    // size and the non-index address bits do not affect the access
    assign unused_bits = ^{data_sram_size, data_sram_addr[31:ADDR_WIDTH+2],
                           data_sram_addr[1:0]};

    assign data_sram_addr_ok = (count < DEPTH_CNT);
    assign accept            = data_sram_req & data_sram_addr_ok;
    assign resp_fire         = q_valid[head] && (q_timer[head] == 4'd0) && !resp_stall;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            head    <= '0;
            tail    <= '0;
            count   <= '0;
            q_valid <= '0;
            for (int i = 0; i < QUEUE_DEPTH; i++) begin
                q_timer[i] <= 4'd0;
            end
        end else begin
            for (int i = 0; i < QUEUE_DEPTH; i++) begin
                if (q_valid[i] && q_timer[i] != 4'd0) begin
                    q_timer[i] <= q_timer[i] - 4'd1;
                end
            end
            // the tail slot is never valid when accepting, so no clash with the decrement
            if (accept) begin
                q_valid[tail] <= 1'b1;
                q_timer[tail] <= TIMER_INIT;
                tail          <= tail + 1'b1;
            end
            if (resp_fire) begin
                q_valid[head] <= 1'b0;
                head          <= head + 1'b1;
            end
            case ({accept, resp_fire})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            q_wr[tail]    <= data_sram_wr;
            q_wstrb[tail] <= data_sram_wstrb;
            q_idx[tail]   <= data_sram_addr[ADDR_WIDTH+1:2];
            q_wdata[tail] <= data_sram_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (resp_fire && q_wr[head]) begin
            for (int k = 0; k < 4; k++) begin
                if (q_wstrb[head][k]) begin
                    mem[q_idx[head]][8*k +: 8] <= q_wdata[head][8*k +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            data_sram_data_ok <= 1'b0;
            data_sram_rdata   <= 32'h0;
        end else begin
            data_sram_data_ok <= resp_fire;
            if (resp_fire && !q_wr[head]) begin
                data_sram_rdata <= mem[q_idx[head]];
            end
        end
    end

endmodule

// File: doc/data_sram_like_slave.md
Name: data_sram_like_slave

Overview:
- Responder end of the data-side SRAM-like interface: accepts req/addr/wr/wstrb/wdata from the CPU and returns addr_ok, data_ok and rdata.
- Backs a word-addressed internal memory array and holds up to QUEUE_DEPTH outstanding requests.
- Each request is answered in order after a fixed programmable latency.
- Used as the data memory for core-level simulation and FPGA bring-up. It exercises the core's data_ok wait paths for loads and stores.

Parameters:
- ADDR_WIDTH, 12, word-index bits; memory holds 2^ADDR_WIDTH 32-bit words.
- LATENCY, 2, cycles from request acceptance to earliest data_ok; legal range 1..15.
- QUEUE_DEPTH, 2, maximum outstanding requests; legal values 2 or 4.

Ports:
- clk  in  1  clock; all state updates on posedge.
- resetn  in  1  asynchronous, active-low reset.
- data_sram_req  in  1  request valid.
- data_sram_wr  in  1  1 = store, 0 = load.
- data_sram_size  in  2  0 = byte, 1 = half, 2 = word; informational only, ignored for access.
- data_sram_wstrb  in  4  byte write enables; used only when wr = 1.
- data_sram_addr  in  32  byte address.
- data_sram_wdata  in  32  store data.
- data_sram_addr_ok  out  1  request accepted this cycle when req is also high.
- data_sram_data_ok  out  1  one-cycle response pulse, one per accepted request.
- data_sram_rdata  out  32  load data; valid only while data_ok = 1 for a load.
- resp_stall  in  1  bench/debug hold; while high, no data_ok is issued.

Behaviour:
- Reset (resetn = 0, async):
  - queue emptied, all timers cleared.
  - data_ok = 0, rdata = 0; addr_ok = 1 once resetn deasserts.
  - Memory array is not reset and powers up as X.
- addr_ok = (count < QUEUE_DEPTH):
  - Registered-state function only; it must not depend combinationally on req.
  - Accept = req & addr_ok.
- On accept, an entry {wr, wstrb, word index = addr[ADDR_WIDTH+1:2], wdata, timer = LATENCY-1} is pushed at the tail.
  - addr bits above ADDR_WIDTH+1 and addr[1:0] are ignored; higher addresses alias.
- Each cycle, every valid entry's timer decrements, saturating at 0.
- Response condition: head valid & head timer == 0 & !resp_stall.
  - On response, data_ok = 1 in the following cycle (registered) and the head is popped at that same edge.
  - Result: a request accepted at edge t sees data_ok high during cycle t+LATENCY at the earliest.
- Store commit happens at the response edge: mem[idx] byte k <= wdata byte k for each wstrb[k] = 1.
  - A store with wstrb = 0 still gets a data_ok.
- Load read happens at the response edge: rdata <= mem[idx]. Loads return full words; byte/half extraction is the core's job.
  - Because responses and commits are strictly in order, a load after a store to the same word returns the updated data.
- On cycles without a response, data_ok = 0 and rdata holds its last value.
- Simultaneous accept and pop in one cycle:
  - count unchanged.
  - A full queue does not raise addr_ok in that same cycle; it raises it the next cycle, since addr_ok comes from registered count.
- Wrap-around: head/tail pointers are log2(QUEUE_DEPTH) bits and wrap naturally; count is 0..QUEUE_DEPTH.
- resp_stall high: timers keep saturating, queue can fill, addr_ok drops at full. Release resumes in-order responses, one per cycle.
- Throughput: with LATENCY = 1 and no stall, one request per cycle is sustained.
- Reset mid-operation: all outstanding requests are dropped silently with no data_ok. Stores not yet committed are lost.

Test Plan:
- Store then load, LATENCY = 2:
  - Store addr 0x0000_0010, wdata 0xDEADBEEF, wstrb 0xF, then load 0x10.
  - data_ok two cycles after each accept; load rdata = 0xDEADBEEF.
- Byte strobes:
  - Store 0x11223344 to 0x20 with wstrb 0xF, then 0xAABBCCDD with wstrb 0x5, then load 0x20.
  - rdata = 0x11BB33DD.
- Back-to-back, LATENCY = 1:
  - req held high for 4 loads from 0x0, 0x4, 0x8, 0xC, each previously written with its address.
  - addr_ok continuously 1; data_ok high on 4 consecutive cycles; rdata 0x0, 0x4, 0x8, 0xC in order.
- Back-pressure:
  - resp_stall = 1, issue 3 requests with QUEUE_DEPTH = 2.
  - addr_ok falls after the 2nd accept and the 3rd req waits.
  - Release stall: data_ok for req1, then req2; 3rd accepted in the cycle after the first pop; 3 data_ok total.
- Aliasing, ADDR_WIDTH = 12:
  - Store 0x5A5A5A5A to 0x0000_4008, load 0x0000_0008.
  - rdata = 0x5A5A5A5A.
- Async reset mid-flight:
  - Two loads outstanding, drop resetn for half a cycle.
  - data_ok = 0 immediately and stays 0, no stale responses, addr_ok = 1 after release.
  - Earlier committed memory contents are preserved.
